// File: rtl/neureka_outfeat_packer_pkg.sv
// Shared types and constants for the output-feature packer that feeds the streamer sink.
// Control/flag payloads, FSM state encoding and slot-width helper.
package neureka_outfeat_packer_pkg;

    localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 256;
    localparam int unsigned OUTPACK_IN_W              = 32;
    localparam int unsigned OUTPACK_LEN_W             = 16;

    typedef struct packed {
        logic                     start;
        logic [OUTPACK_LEN_W-1:0] len;
    } ctrl_outpack_t;

    typedef struct packed {
        logic                     busy;
        logic                     done;
        logic [OUTPACK_LEN_W-1:0] beat_cnt;
    } flags_outpack_t;

    typedef enum logic [1:0] {
        OUTPACK_IDLE = 2'd0,
        OUTPACK_PACK = 2'd1,
        OUTPACK_DONE = 2'd2
    } outpack_state_e;

    // Slot index width; a single-slot beat still needs a 1-bit index.
    function automatic int unsigned outpack_slot_w(input int unsigned wpb);
        return (wpb > 1) ? $clog2(wpb) : 1;
    endfunction

endpackage

// File: rtl/neureka_outfeat_packer_if.sv
// Valid/ready stream with byte strobe; master drives payload, slave drives ready.
interface neureka_outfeat_packer_if #(
    parameter int unsigned DATA_W = 32
);

    logic                  valid;
    logic                  ready;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);

endinterface

// File: rtl/neureka_outfeat_packer.sv
// Packs narrow output-feature words into full-bandwidth beats with byte strobes;
// the final beat of a job is emitted partially filled with zero data/strobe in unused slots.
module neureka_outfeat_packer
    import neureka_outfeat_packer_pkg::*;
#(
    parameter int unsigned IN_W  = OUTPACK_IN_W,
    parameter int unsigned BW    = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter int unsigned LEN_W = OUTPACK_LEN_W
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            enable_i,
    neureka_outfeat_packer_if.slave         push_i,
    neureka_outfeat_packer_if.master        pop_o,
    input  logic                            start_i,
    input  logic [LEN_W-1:0]                len_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [LEN_W-1:0]                beat_cnt_o
);

    localparam int unsigned WPB    = BW / IN_W;
    localparam int unsigned SLOT_W = outpack_slot_w(WPB);
    localparam int unsigned IN_B   = IN_W / 8;
    localparam int unsigned BW_B   = BW / 8;

    if (((BW % IN_W) != 0) || ((IN_W % 8) != 0)) begin : g_param_check
        $error("neureka_outfeat_packer: BW must be a multiple of IN_W and IN_W a multiple of 8");
    end

    outpack_state_e    state;
    logic [LEN_W-1:0]  remaining;
    logic [SLOT_W-1:0] slot;
    logic [BW-1:0]     beat_data;
    logic [BW_B-1:0]   beat_strb;
    logic              beat_valid;

    logic              push_ready;
    logic              push_hs;
    logic              pop_hs;
    logic              beat_full;
    logic [BW-1:0]     data_nxt;
    logic [BW_B-1:0]   strb_nxt;

    // Accept only while a job has words left and the beat register is free or draining.
    assign push_ready = enable_i & (state == OUTPACK_PACK) & (remaining != '0)
                      & (~beat_valid | pop_o.ready);
    assign push_hs    = push_i.valid & push_ready;
    assign pop_hs     = enable_i & beat_valid & pop_o.ready;
    assign beat_full  = (slot == SLOT_W'(WPB - 1)) | (remaining == LEN_W'(1));

    assign push_i.ready = push_ready;
    assign pop_o.valid  = enable_i & beat_valid;
    assign pop_o.data   = beat_data;
    assign pop_o.strb   = beat_strb;

    // Slot write-decode: slot 0 starts a fresh beat, so stale words/strobes are wiped.
    always_comb begin
        data_nxt = (slot == '0) ? '0 : beat_data;
        strb_nxt = (slot == '0) ? '0 : beat_strb;
        for (int unsigned i = 0; i < WPB; i++) begin
            if (slot == SLOT_W'(i)) begin
                data_nxt[i*IN_W +: IN_W] = push_i.data;
                strb_nxt[i*IN_B +: IN_B] = push_i.strb;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= OUTPACK_IDLE;
            remaining  <= '0;
            slot       <= '0;
            beat_data  <= '0;
            beat_strb  <= '0;
            beat_valid <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            beat_cnt_o <= '0;
        end else if (clear_i) begin
            state      <= OUTPACK_IDLE;
            remaining  <= '0;
            slot       <= '0;
            beat_data  <= '0;
            beat_strb  <= '0;
            beat_valid <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            beat_cnt_o <= '0;
        end else if (enable_i) begin
            unique case (state)
                OUTPACK_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        beat_cnt_o <= '0;
                        if (len_i != '0) begin
                            remaining  <= len_i;
                            slot       <= '0;
                            beat_data  <= '0;
                            beat_strb  <= '0;
                            beat_valid <= 1'b0;
                            busy_o     <= 1'b1;
                            state      <= OUTPACK_PACK;
                        end else begin
                            done_o <= 1'b1;
                            state  <= OUTPACK_DONE;
                        end
                    end
                end

                OUTPACK_PACK: begin
                    if (pop_hs) begin
                        beat_valid <= 1'b0;
                        beat_cnt_o <= beat_cnt_o + LEN_W'(1);
                    end
                    // A push completing a beat overrides the pop's clear above.
                    if (push_hs) begin
                        beat_data <= data_nxt;
                        beat_strb <= strb_nxt;
                        remaining <= remaining - LEN_W'(1);
                        if (beat_full) begin
                            beat_valid <= 1'b1;
                            slot       <= '0;
                        end else begin
                            slot <= slot + SLOT_W'(1);
                        end
                    end
                    if ((remaining == '0) && !beat_valid) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= OUTPACK_DONE;
                    end
                end

                OUTPACK_DONE: begin
                    done_o <= 1'b0;
                    state  <= OUTPACK_IDLE;
                end

                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= OUTPACK_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neureka_outfeat_packer.sv
// Scoreboard bench for the output-feature packer: expected beats are queued as words are
// driven and compared whenever a beat is handed downstream.
module tb_neureka_outfeat_packer;
    import neureka_outfeat_packer_pkg::*;

    localparam int unsigned IN_W  = 32;
    localparam int unsigned BW    = 256;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned WPB   = BW / IN_W;
    localparam int unsigned IN_B  = IN_W / 8;
    localparam int unsigned CW    = 256;

    typedef struct packed {
        logic [BW-1:0]   data;
        logic [BW/8-1:0] strb;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             enable;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] beat_cnt;

    beat_t            exp_q[$];
    int               total = 0;
    int               bad   = 0;
    int               pops  = 0;
    int               dones = 0;
    logic [BW-1:0]    last_data;
    logic [BW/8-1:0]  last_strb;

    neureka_outfeat_packer_if #(.DATA_W(IN_W)) push_if ();
    neureka_outfeat_packer_if #(.DATA_W(BW))   pop_if ();

    neureka_outfeat_packer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .enable_i   (enable),
        .push_i     (push_if),
        .pop_o      (pop_if),
        .start_i    (start),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .beat_cnt_o (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Downstream monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) dones <= dones + 1;
        if (pop_if.valid && pop_if.ready) begin
            pops      <= pops + 1;
            last_data <= pop_if.data;
            last_strb <= pop_if.strb;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", CW'(1), CW'(0));
            end else begin
                chk("beat_data", CW'(pop_if.data), CW'(exp_q[0].data));
                chk("beat_strb", CW'(pop_if.strb), CW'(exp_q[0].strb));
                exp_q.delete(0);
            end
        end
    end

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_words(input int n, input int bad_idx, input logic [3:0] bad_strb,
                              input bit add_exp, output int stalls);
        logic [IN_W-1:0] w[$];
        bit              hs;
        stalls = 0;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        if (add_exp) begin
            for (int b = 0; b * WPB < n; b++) begin
                beat_t e;
                e = '0;
                for (int s = 0; s < WPB && (b * WPB + s) < n; s++) begin
                    e.data[s*IN_W +: IN_W] = w[b*WPB + s];
                    e.strb[s*IN_B +: IN_B] = ((b * WPB + s) == bad_idx) ? bad_strb : 4'hF;
                end
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            push_if.valid = 1'b1;
            push_if.data  = w[i];
            push_if.strb  = (i == bad_idx) ? bad_strb : 4'hF;
            hs = 1'b0;
            for (int t = 0; t < 100 && !hs; t++) begin
                @(negedge clk);
                if (push_if.ready) hs = 1'b1;
                else if (i > 0) stalls++;
                @(posedge clk); #1;
            end
            if (!hs) chk("push_timeout", CW'(0), CW'(1));
        end
        push_if.valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, CW'(seen), CW'(1));
        chk({tag, "_busy_at_done"}, CW'(busy), CW'(0));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, CW'(done), CW'(0));
        @(posedge clk); #1;
    endtask

    // Holds a full beat under backpressure, then releases it while the next word waits.
    task automatic stall_probe();
        logic [BW-1:0]   d0;
        logic [BW/8-1:0] s0;
        bit              seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (pop_if.valid) seen = 1'b1;
        end
        chk("bp_valid_seen", CW'(seen), CW'(1));
        d0 = pop_if.data;
        s0 = pop_if.strb;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_data_stable", CW'(pop_if.data), CW'(d0));
            chk("bp_strb_stable", CW'(pop_if.strb), CW'(s0));
            chk("bp_push_ready_low", CW'(push_if.ready), CW'(0));
        end
        @(posedge clk); #1;
        pop_if.ready = 1'b1;
        @(negedge clk);
        chk("bp_release_pop", CW'(pop_if.valid), CW'(1));
        chk("bp_release_push", CW'(push_if.ready && push_if.valid), CW'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int stalls;
        int p0;
        int d0;
        rst           = 1'b1;
        clear         = 1'b0;
        enable        = 1'b1;
        start         = 1'b0;
        len           = '0;
        push_if.valid = 1'b0;
        push_if.data  = '0;
        push_if.strb  = '0;
        pop_if.ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_done", CW'(done), CW'(0));
        chk("rst_beat_cnt", CW'(beat_cnt), CW'(0));
        chk("rst_pop_valid", CW'(pop_if.valid), CW'(0));
        chk("rst_pop_data", CW'(pop_if.data), CW'(0));
        chk("rst_pop_strb", CW'(pop_if.strb), CW'(0));
        chk("rst_push_ready", CW'(push_if.ready), CW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Two full beats, full throughput.
        p0 = pops;
        d0 = dones;
        start_job(16);
        chk("t1_busy", CW'(busy), CW'(1));
        push_words(16, -1, 4'h0, 1'b1, stalls);
        chk("t1_no_stalls", CW'(stalls), CW'(0));
        wait_done("t1");
        chk("t1_beat_cnt", CW'(beat_cnt), CW'(2));
        chk("t1_pops", CW'(pops - p0), CW'(2));
        chk("t1_done_pulses", CW'(dones - d0), CW'(1));

        // Partial final beat.
        start_job(11);
        push_words(11, -1, 4'h0, 1'b1, stalls);
        wait_done("t2");
        chk("t2_beat_cnt", CW'(beat_cnt), CW'(2));
        chk("t2_last_strb", CW'(last_strb), CW'(32'h0000_0FFF));
        chk("t2_upper_zero", CW'(last_data[BW-1:3*IN_W]), CW'(0));

        // Backpressure on the first beat.
        pop_if.ready = 1'b0;
        start_job(16);
        fork
            push_words(16, -1, 4'h0, 1'b1, stalls);
            stall_probe();
        join
        wait_done("t3");
        chk("t3_beat_cnt", CW'(beat_cnt), CW'(2));

        // Empty job.
        p0 = pops;
        start = 1'b1;
        len   = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_done", CW'(done), CW'(1));
        chk("t4_busy", CW'(busy), CW'(0));
        chk("t4_pop_valid", CW'(pop_if.valid), CW'(0));
        @(negedge clk);
        chk("t4_done_gone", CW'(done), CW'(0));
        chk("t4_busy_after", CW'(busy), CW'(0));
        chk("t4_no_pops", CW'(pops - p0), CW'(0));
        @(posedge clk); #1;

        // Mid-job clear, then a clean job.
        d0 = dones;
        p0 = pops;
        start_job(16);
        push_words(5, -1, 4'h0, 1'b0, stalls);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("t5_state_idle", CW'(dut.state), CW'(OUTPACK_IDLE));
        chk("t5_busy", CW'(busy), CW'(0));
        chk("t5_pop_valid", CW'(pop_if.valid), CW'(0));
        chk("t5_push_ready", CW'(push_if.ready), CW'(0));
        repeat (3) @(negedge clk);
        chk("t5_no_done", CW'(dones - d0), CW'(0));
        chk("t5_no_pops", CW'(pops - p0), CW'(0));
        @(posedge clk); #1;
        start_job(8);
        push_words(8, -1, 4'h0, 1'b1, stalls);
        wait_done("t5b");
        chk("t5b_beat_cnt", CW'(beat_cnt), CW'(1));

        // Partial strobe on word 3.
        start_job(8);
        push_words(8, 3, 4'b0011, 1'b1, stalls);
        wait_done("t6");
        chk("t6_strb", CW'(last_strb), CW'(32'hFFFF_3FFF));
        chk("t6_beat_cnt", CW'(beat_cnt), CW'(1));

        chk("scoreboard_empty", CW'(exp_q.size()), CW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
